// File: rtl/stream_prefetcher_pkg.sv
// Shared cache types and constants for the stream prefetcher.
package stream_prefetcher_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [7:0]  uint8_t;

    localparam int unsigned PAGE_BYTES = 4096;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        SP_IDLE,
        SP_WAIT_ARREADY,
        SP_RECEIVING,
        SP_FLUSH_WAIT_ARREADY,
        SP_FLUSH_RECEIVING
    } sp_state_t;

endpackage

// File: rtl/axi3_rd_if.sv
// AXI3 read address and read data channels, 32-bit data.
interface axi3_rd_if;
    import stream_prefetcher_pkg::*;

    logic [3:0]  arid;
    phys_t       araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/stream_prefetcher_line_fifo.sv
// DEPTH-entry FIFO of (label, line) pairs; lines are assembled word by word in the tail slot.
module sp_line_fifo #(
    parameter  int unsigned LABEL_WIDTH = 27,
    parameter  int unsigned LINE_WIDTH  = 256,
    parameter  int unsigned DEPTH       = 4,
    localparam int unsigned PTR_W       = $clog2(DEPTH),
    localparam int unsigned CNT_W       = PTR_W + 1,
    localparam int unsigned BEATS       = LINE_WIDTH / 32,
    localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   word_we,
    input  logic [BEAT_W-1:0]      word_idx,
    input  logic [31:0]            word_data,
    input  logic                   push,
    input  logic [LABEL_WIDTH-1:0] push_label,
    input  logic                   pop,
    output logic                   head_vld,
    output logic [LABEL_WIDTH-1:0] head_label,
    output logic [LINE_WIDTH-1:0]  head_data,
    output logic [CNT_W-1:0]       count
);

    logic [LABEL_WIDTH-1:0] labels [DEPTH];
    logic [LINE_WIDTH-1:0]  lines  [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic                   pop_ok;

    assign pop_ok     = pop & (count != '0);
    assign head_vld   = (count != '0);
    assign head_label = labels[head];
    assign head_data  = lines[head];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop_ok)
                head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (word_we)
            lines[tail][32*int'(word_idx) +: 32] <= word_data;
        if (push)
            labels[tail] <= push_label;
    end

endmodule

// File: rtl/stream_prefetcher.sv
// Sequential-line stream prefetcher with a DEPTH-line FIFO fed over its own AXI3 read ID.
// Optional STREAM_PREFETCHER_PAGE_STOP_EN: stop fetching at 4 KiB page boundaries.
module stream_prefetcher
    import stream_prefetcher_pkg::*;
#(
    parameter  int unsigned LINE_WIDTH       = 256,
    parameter  int unsigned DEPTH            = 4,
    parameter  int unsigned ARID             = 2,
    localparam int unsigned LINE_BYTE_OFFSET = $clog2(LINE_WIDTH / 8),
    localparam int unsigned LABEL_WIDTH      = $bits(phys_t) - LINE_BYTE_OFFSET
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LABEL_WIDTH-1:0] miss_label,
    input  logic                   miss_vld,
    input  logic [LABEL_WIDTH-1:0] probe_label,
    input  logic                   probe_vld,
    input  logic                   inv,
    output logic                   hit,
    output logic [LINE_WIDTH-1:0]  hit_data,
    output logic                   busy,
    axi3_rd_if.master              axi
);

    localparam int unsigned BEATS  = LINE_WIDTH / 32;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    sp_state_t              state, state_n;
    logic [LABEL_WIDTH-1:0] next_label, cur_label, fetch_label;
    logic [BEAT_W-1:0]      beat;
    logic                   stopped, page_stop;
    logic                   arvalid_q, rready_q, busy_q;
    logic                   restart, kill, issue, ar_hs, r_hs, word_we, commit;
    logic                   head_vld;
    logic [LABEL_WIDTH-1:0] head_label;
    logic [CNT_W-1:0]       count;
    logic                   unused_ok;

    assign hit     = probe_vld & head_vld & (head_label == probe_label);
    assign restart = miss_vld & ~hit;
    assign kill    = inv | restart;
    assign ar_hs   = axi.arvalid & axi.arready;
    assign r_hs    = axi.rvalid & axi.rready;
    assign word_we = (state == SP_RECEIVING) & r_hs & ~kill;
    assign commit  = word_we & axi.rlast;

    assign fetch_label = restart ? miss_label + LABEL_WIDTH'(1) : next_label;
    assign issue = (state == SP_IDLE) & ~inv &
                   (restart | (~stopped & (count < CNT_W'(DEPTH))));

`ifdef STREAM_PREFETCHER_PAGE_STOP_EN
    localparam int unsigned PAGE_LINE_BITS = $clog2(PAGE_BYTES) - LINE_BYTE_OFFSET;
    logic [LABEL_WIDTH-1:0] label_inc;
    assign label_inc = cur_label + LABEL_WIDTH'(1);
    assign page_stop = (label_inc[PAGE_LINE_BITS-1:0] == '0);
`else
    assign page_stop = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            SP_IDLE:               if (issue) state_n = SP_WAIT_ARREADY;
            SP_WAIT_ARREADY:       if (kill) state_n = ar_hs ? SP_FLUSH_RECEIVING : SP_FLUSH_WAIT_ARREADY;
                                   else if (ar_hs) state_n = SP_RECEIVING;
            SP_RECEIVING:          if (r_hs && axi.rlast) state_n = SP_IDLE;
                                   else if (kill) state_n = SP_FLUSH_RECEIVING;
            SP_FLUSH_WAIT_ARREADY: if (ar_hs) state_n = SP_FLUSH_RECEIVING;
            SP_FLUSH_RECEIVING:    if (r_hs && axi.rlast) state_n = SP_IDLE;
            default:               state_n = SP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SP_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            busy_q     <= 1'b0;
            next_label <= '0;
            cur_label  <= '0;
            beat       <= '0;
            stopped    <= 1'b1;
        end else begin
            state     <= state_n;
            arvalid_q <= (state_n inside {SP_WAIT_ARREADY, SP_FLUSH_WAIT_ARREADY});
            rready_q  <= (state_n inside {SP_RECEIVING, SP_FLUSH_RECEIVING});
            busy_q    <= (state_n != SP_IDLE);
            // The request address is frozen in cur_label so araddr holds steady while arvalid is up.
            if (issue)
                cur_label <= fetch_label;
            if (ar_hs)
                beat <= '0;
            else if (r_hs)
                beat <= beat + BEAT_W'(1);
            if (state == SP_WAIT_ARREADY && ar_hs && !kill)
                next_label <= cur_label + LABEL_WIDTH'(1);
            if (restart)
                next_label <= miss_label + LABEL_WIDTH'(1);
            if (inv)
                stopped <= 1'b1;
            else if (restart)
                stopped <= 1'b0;
            else if (state == SP_WAIT_ARREADY && ar_hs && page_stop)
                stopped <= 1'b1;
        end
    end

    sp_line_fifo #(
        .LABEL_WIDTH (LABEL_WIDTH),
        .LINE_WIDTH  (LINE_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (kill),
        .word_we    (word_we),
        .word_idx   (beat),
        .word_data  (axi.rdata),
        .push       (commit),
        .push_label (cur_label),
        .pop        (hit),
        .head_vld   (head_vld),
        .head_label (head_label),
        .head_data  (hit_data),
        .count      (count)
    );

    assign busy        = busy_q;
    assign axi.arid    = 4'(ARID);
    assign axi.araddr  = {cur_label, {LINE_BYTE_OFFSET{1'b0}}};
    assign axi.arlen   = 4'(BEATS - 1);
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign unused_ok   = ^{axi.rid, axi.rresp};

endmodule

// File: tb/tb_stream_prefetcher.sv
// Directed bench for stream_prefetcher with a simple in-order AXI3 read slave.
module tb_stream_prefetcher;
    import stream_prefetcher_pkg::*;

    localparam int unsigned LW    = 256;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ARID  = 2;
    localparam int unsigned LBW   = 27;
    localparam int unsigned BEATS = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [LBW-1:0] miss_label, probe_label;
    logic           miss_vld, probe_vld, inv;
    logic           hit, busy;
    logic [LW-1:0]  hit_data;

    axi3_rd_if axi ();

    stream_prefetcher #(.LINE_WIDTH(LW), .DEPTH(DEPTH), .ARID(ARID)) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_label  (miss_label),
        .miss_vld    (miss_vld),
        .probe_label (probe_label),
        .probe_vld   (probe_vld),
        .inv         (inv),
        .hit         (hit),
        .hit_data    (hit_data),
        .busy        (busy),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model state: accepted AR addresses, current burst, beats accepted this burst.
    bit          ar_ok;
    logic [31:0] ar_q[$];
    bit          sl_busy;
    logic [31:0] sl_addr;
    int unsigned sl_beat;
    int unsigned beats_seen;

    initial begin : slave
        bit ar_hs, r_hs;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rdata = '0; axi.rid = 4'(ARID); axi.rresp = '0;
        sl_busy = 1'b0; sl_addr = '0; sl_beat = 0; beats_seen = 0;
        forever begin
            @(posedge clk);
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            #1;
            if (rst) begin
                sl_busy = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
                continue;
            end
            if (r_hs) begin
                beats_seen++;
                if (sl_beat == BEATS - 1) sl_busy = 1'b0;
                else sl_beat++;
            end
            if (ar_hs) begin
                ar_q.push_back(axi.araddr);
                sl_addr = axi.araddr; sl_busy = 1'b1; sl_beat = 0; beats_seen = 0;
            end
            axi.arready = ar_ok && !sl_busy;
            axi.rvalid  = sl_busy;
            axi.rlast   = sl_busy && (sl_beat == BEATS - 1);
            axi.rdata   = sl_addr + 4 * sl_beat;
        end
    end

    function automatic logic [LW-1:0] line_of(input logic [LBW-1:0] lbl);
        logic [31:0]   a;
        logic [LW-1:0] r;
        a = {lbl, 5'b0};
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = a + 32'(4 * k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_ars(input int unsigned n, input string tag);
        int k = 0;
        while (ar_q.size() < n && k < 500) begin step(); k++; end
        chk({tag, "_ar_wait"}, ar_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin step(); k++; end
        chk({tag, "_idle_wait"}, busy, 0);
    endtask

    initial begin : stim
        int          k;
        int unsigned base;
        rst = 1'b1; miss_vld = 1'b0; miss_label = '0; probe_vld = 1'b1; probe_label = '0;
        inv = 1'b0; ar_ok = 1'b1;
        step(3);
        chk("rst_hit", hit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        rst = 1'b0; probe_vld = 1'b0;
        step(2);
        chk("idle_no_issue", axi.arvalid, 0);

        // Stream from miss 0x100: fills 0x101..0x104 then stops (full).
        miss_label = 27'h100; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("first_arvalid", axi.arvalid, 1);
        chk("first_araddr", axi.araddr, 32'h2020);
        chk("arlen", axi.arlen, 7);
        chk("arsize", axi.arsize, 3'b010);
        chk("arburst", axi.arburst, 2'b01);
        chk("arid", axi.arid, 2);
        wait_ars(4, "fill");
        chk("ar0", ar_q[0], 32'h2020);
        chk("ar1", ar_q[1], 32'h2040);
        chk("ar2", ar_q[2], 32'h2060);
        chk("ar3", ar_q[3], 32'h2080);
        wait_idle("fill");
        step(10);
        chk("full_no_arvalid", axi.arvalid, 0);
        chk("full_ar_count", ar_q.size(), 4);

        // Head hit, pop, refill of the freed slot.
        probe_label = 27'h101; probe_vld = 1'b1; #1;
        chk("hit_101", hit, 1);
        chk("data_101", hit_data, line_of(27'h101));
        step(); probe_vld = 1'b0;
        step();
        chk("refill_arvalid", axi.arvalid, 1);
        chk("refill_araddr", axi.araddr, 32'h20A0);
        wait_ars(5, "refill");
        wait_idle("refill");
        step(4);

        // Non-head probe misses; the miss restarts the stream and flushes.
        probe_label = 27'h105; probe_vld = 1'b1; #1;
        chk("probe_105_miss", hit, 0);
        miss_label = 27'h105; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        probe_label = 27'h102; #1;
        chk("restart_flushed", hit, 0);
        chk("restart_arvalid", axi.arvalid, 1);
        chk("restart_araddr", axi.araddr, 32'h20C0);
        probe_vld = 1'b0;

        // inv during beat 3: drain without commit, stream stops.
        k = 0;
        while (!(axi.rvalid && axi.rready && sl_beat == 3) && k < 100) begin step(); k++; end
        chk("beat3_reached", sl_beat, 3);
        inv = 1'b1; step(); inv = 1'b0;
        chk("drain_rready", axi.rready, 1);
        chk("drain_busy", busy, 1);
        wait_idle("drain");
        chk("drain_beats", beats_seen, 8);
        base = ar_q.size();
        step(6);
        chk("inv_stops_stream", ar_q.size(), base);
        chk("inv_no_arvalid", axi.arvalid, 0);
        probe_label = 27'h106; probe_vld = 1'b1; #1;
        chk("inv_empty", hit, 0);
        probe_vld = 1'b0;

        // All-ones miss: next label wraps to zero.
        miss_label = '1; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("wrap_arvalid", axi.arvalid, 1);
        chk("wrap_araddr", axi.araddr, 32'h0);
        base = ar_q.size();
        wait_ars(base + 4, "wrap");
        chk("wrap_ar1", ar_q[base+1], 32'h20);
        chk("wrap_ar3", ar_q[base+3], 32'h60);
        wait_idle("wrap");
        step(4);

        // Hit and miss together: hit wins, stream continues at label 4.
        probe_label = '0; probe_vld = 1'b1; miss_label = 27'h50; miss_vld = 1'b1; #1;
        chk("prio_hit", hit, 1);
        chk("data_0", hit_data, line_of(27'h0));
        step(); miss_vld = 1'b0; probe_vld = 1'b0;
        wait_ars(base + 5, "prio");
        chk("prio_continue", ar_q[base+4], 32'h80);
        wait_idle("prio");
        step(4);

        // Page boundary at label 0x080.
        base = ar_q.size();
        miss_label = 27'h07E; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("page_araddr", axi.araddr, 32'h0FE0);
`ifdef STREAM_PREFETCHER_PAGE_STOP_EN
        wait_idle("page");
        step(10);
        chk("page_stop_count", ar_q.size(), base + 1);
`else
        wait_ars(base + 2, "page");
        chk("page_cross", ar_q[base+1], 32'h1000);
`endif
        inv = 1'b1; step(); inv = 1'b0;
        wait_idle("page_inv");
        step(2);

        // Restart while arvalid is pending: address held, next_label retargeted.
        ar_ok = 1'b0; step(2);
        miss_label = 27'h200; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("wait_araddr", axi.araddr, 32'h4020);
        miss_label = 27'h300; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("flush_wait_arvalid", axi.arvalid, 1);
        chk("flush_wait_araddr", axi.araddr, 32'h4020);
        chk("flush_wait_busy", busy, 1);
        base = ar_q.size();
        ar_ok = 1'b1;
        wait_ars(base + 2, "retarget");
        chk("retarget_ar0", ar_q[base], 32'h4020);
        chk("retarget_ar1", ar_q[base+1], 32'h6020);
        probe_label = 27'h301; probe_vld = 1'b1;
        k = 0;
        while (hit !== 1'b1 && k < 100) begin step(); k++; end
        chk("retarget_hit", hit, 1);
        chk("retarget_data", hit_data, line_of(27'h301));
        step(); probe_vld = 1'b0;
        inv = 1'b1; step(); inv = 1'b0;
        wait_idle("pre_rst");

        // Reset while waiting for arready.
        ar_ok = 1'b0; step(2);
        miss_label = 27'h200; miss_vld = 1'b1; step(); miss_vld = 1'b0;
        chk("pre_rst_arvalid", axi.arvalid, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; probe_label = 27'h201; probe_vld = 1'b1;
        step();
        chk("mid_rst_arvalid", axi.arvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hit", hit, 0);
        rst = 1'b0; probe_vld = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
